// File: rtl/iu_divider.sv
`timescale 1ns/1ps
// iu_divider: multi-cycle SPARC V8 integer divider (UDIV/SDIV/UDIVcc/SDIVcc).
// Divides the 64-bit dividend {y_in, a} by b with a radix-2 restoring loop
// that produces one quotient bit per cycle. Results saturate on overflow, and
// divide-by-zero is reported on div_zero.
// Optional feature macro: IUDIV_FASTPATH_EN. When it is defined, a zero
// dividend with a nonzero divisor finishes straight from PREP.
module iu_divider #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] y_in,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic [3:0]  flags,
    output logic        flags_we,
    output logic        div_zero
);

    localparam logic [5:0] OP_UDIV   = 6'b001110;
    localparam logic [5:0] OP_SDIV   = 6'b001111;
    localparam logic [5:0] OP_UDIVCC = 6'b011110;
    localparam logic [5:0] OP_SDIVCC = 6'b011111;
    localparam logic [4:0] CNT_LAST  = 5'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // {N,Z,V,C} for a final quotient; C is always clear for divides.
    function automatic logic [3:0] calc_flags(input logic [31:0] v, input logic ovf);
        return {v[31], (v == 32'd0), ovf, 1'b0};
    endfunction

    // Saturated quotient reported on overflow.
    function automatic logic [31:0] sat_value(input logic is_signed, input logic neg);
        logic [31:0] v;
        if (!is_signed) begin
            v = 32'hFFFF_FFFF;
        end else if (neg) begin
            v = 32'h8000_0000;
        end else begin
            v = 32'h7FFF_FFFF;
        end
        return v;
    endfunction

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_rd;
    logic [3:0]  r_flags;
    logic        r_flags_we;
    logic        r_div_zero;
    logic        r_signed;
    logic        r_cc;
    logic [31:0] r_a;
    logic [31:0] r_y;
    logic [31:0] r_b;
    logic        r_sign_q;
    logic [31:0] r_div;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [4:0]  r_cnt;

    logic        w_op_legal;
    logic [63:0] w_dividend;
    logic [63:0] w_dmag;
    logic [31:0] w_bmag;
    logic        w_sign_q;
    logic        w_prep_ovf;
    logic [31:0] w_prep_sat;
    logic        w_b_zero;
    logic [32:0] w_rem_sh;
    logic        w_qbit;
    logic [31:0] w_rem_next;
    logic        w_fix_ovf;
    logic [31:0] w_fix_val;
    logic [31:0] w_fix_rd;
`ifdef IUDIV_FASTPATH_EN
    logic        w_d_zero;
`endif

    // Accept only the four divide opcodes.
    always_comb begin
        case (op)
            OP_UDIV, OP_SDIV, OP_UDIVCC, OP_SDIVCC: w_op_legal = 1'b1;
            default:                                w_op_legal = 1'b0;
        endcase
    end

    // PREP: operand magnitudes, quotient sign and the early-overflow test.
    always_comb begin
        w_dividend = {r_y, r_a};
        if (r_signed && w_dividend[63]) begin
            w_dmag = 64'd0 - w_dividend;
        end else begin
            w_dmag = w_dividend;
        end
        if (r_signed && r_b[31]) begin
            w_bmag = 32'd0 - r_b;
        end else begin
            w_bmag = r_b;
        end
        w_sign_q   = r_signed & (r_y[31] ^ r_b[31]);
        // High magnitude word >= divisor means the quotient cannot fit in 32 bits.
        w_prep_ovf = (w_dmag[63:32] >= w_bmag);
        w_prep_sat = sat_value(r_signed, w_sign_q);
        w_b_zero   = (r_b == 32'd0);
`ifdef IUDIV_FASTPATH_EN
        w_d_zero   = (w_dividend == 64'd0);
`endif
    end

    // ITER: restoring step; the remainder stays below the divisor, so 32 stored bits plus the shifted-in bit suffice.
    always_comb begin
        w_rem_sh = {r_rem, r_q[31]};
        w_qbit   = (w_rem_sh >= {1'b0, r_div});
        if (w_qbit) begin
            w_rem_next = w_rem_sh[31:0] - r_div;
        end else begin
            w_rem_next = w_rem_sh[31:0];
        end
    end

    // FIX: apply the quotient sign and catch signed overflow of the magnitude.
    always_comb begin
        if (r_sign_q) begin
            w_fix_ovf = r_signed && (r_q > 32'h8000_0000);
            w_fix_val = 32'd0 - r_q;
        end else begin
            w_fix_ovf = r_signed && (r_q > 32'h7FFF_FFFF);
            w_fix_val = r_q;
        end
        if (w_fix_ovf) begin
            w_fix_rd = sat_value(r_signed, r_sign_q);
        end else begin
            w_fix_rd = w_fix_val;
        end
    end

    // Control FSM with registered outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd       <= 32'd0;
            r_flags    <= 4'd0;
            r_flags_we <= 1'b0;
            r_div_zero <= 1'b0;
            r_signed   <= 1'b0;
            r_cc       <= 1'b0;
            r_a        <= 32'd0;
            r_y        <= 32'd0;
            r_b        <= 32'd0;
            r_sign_q   <= 1'b0;
            r_div      <= 32'd0;
            r_rem      <= 32'd0;
            r_q        <= 32'd0;
            r_cnt      <= 5'd0;
        end else begin
            // The completion strobes last exactly one cycle.
            r_done     <= 1'b0;
            r_flags_we <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_op_legal) begin
                        r_signed <= op[0];
                        r_cc     <= op[4];
                        r_a      <= a;
                        r_y      <= y_in;
                        r_b      <= b;
                        r_busy   <= 1'b1;
                        r_state  <= S_PREP;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_PREP: begin
                    r_sign_q <= w_sign_q;
                    r_div    <= w_bmag;
                    r_rem    <= w_dmag[63:32];
                    r_q      <= w_dmag[31:0];
                    r_cnt    <= 5'd0;
                    if (w_b_zero) begin
                        // Trap case: rd and flags keep their previous values.
                        r_div_zero <= 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
`ifdef IUDIV_FASTPATH_EN
                    end else if (w_d_zero) begin
                        r_rd       <= 32'd0;
                        r_flags    <= 4'b0100;
                        r_flags_we <= r_cc;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
`endif
                    end else if (w_prep_ovf) begin
                        r_rd       <= w_prep_sat;
                        r_flags    <= calc_flags(w_prep_sat, 1'b1);
                        r_flags_we <= r_cc;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[30:0], w_qbit};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_FIX: begin
                    r_rd       <= w_fix_rd;
                    r_flags    <= calc_flags(w_fix_rd, w_fix_ovf);
                    r_flags_we <= r_cc;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd       = r_rd;
    assign flags    = r_flags;
    assign flags_we = r_flags_we;
    assign div_zero = r_div_zero;

endmodule
